// File: rtl/d_array_tracker_pkg.sv
// d_array_tracker_pkg
// Shared constants for the D-array token tracker: tap count, FSM state
// encodings and the special token-position codes.
package d_array_tracker_pkg;

  localparam int NUM_TAPS = 5;

  // FSM state encodings (3-bit)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRACK = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Token position codes
  localparam logic [2:0] POS_NONE   = 3'd0;
  localparam logic [2:0] POS_FIRST  = 3'd1;
  localparam logic [2:0] POS_MULTI  = 3'd7;

  // Position code of the last tap, where a pass completes.
  localparam logic [2:0] POS_LAST = 3'(NUM_TAPS);

  // True when the state keeps the tracker busy.
  function automatic logic state_is_busy(input logic [2:0] st);
    return (st == ST_TRACK) || (st == ST_ARM);
  endfunction

endpackage

// File: rtl/d_array_tracker_onehot_enc.sv
// d_array_onehot_enc
// Combinational encoder: 5-bit tap vector -> 3-bit token position.
// Ports:
//   vec_i [4:0] : tap vector {q5,q4,q3,q2,q1}
//   pos_o [2:0] : 0 = no tap high, 1..5 = single tap, 7 = more than one tap high
module d_array_onehot_enc
  import d_array_tracker_pkg::*;
(
  input  logic [4:0] vec_i,
  output logic [2:0] pos_o
);

  always_comb begin
    pos_o = POS_MULTI;
    case (vec_i)
      5'b00000: pos_o = POS_NONE;
      5'b00001: pos_o = 3'd1;
      5'b00010: pos_o = 3'd2;
      5'b00100: pos_o = 3'd3;
      5'b01000: pos_o = 3'd4;
      5'b10000: pos_o = 3'd5;
      default:  pos_o = POS_MULTI;
    endcase
  end

endmodule

// File: rtl/d_array_tracker.sv
// d_array_tracker
// Consumer of the 5-tap D flip-flop shift array. Checks that a single-cycle
// token launched at q1 walks to q5 one tap per clock, counts clean passes,
// pulses done after NUM_PASSES passes and latches a sticky error on any
// protocol violation. All outputs are registered.
// Ports:
//   clk            : rising-edge clock shared with the shift array
//   reset          : synchronous active-high reset
//   q1..q5         : shift-array taps
//   pos [2:0]      : registered token position (0 none, 1..5 tap, 7 multi)
//   busy           : high while tracking a pass or armed for the next launch
//   done           : one-cycle pulse when NUM_PASSES passes complete
//   err            : sticky protocol error, cleared only by reset
//   pass_count[3:0]: completed passes since the last launch from idle
//
// state | meaning
// IDLE  | waiting for the first launch (v == 00001)
// TRACK | token in flight, expecting it at tap exp
// ARM   | pass complete, waiting up to TIMEOUT idle cycles for next launch
// DONE  | all passes complete, done pulsed for this one cycle
// ERR   | protocol violation seen, held until reset
module d_array_tracker
  import d_array_tracker_pkg::*;
#(
  parameter int NUM_PASSES = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       q1,
  input  logic       q2,
  input  logic       q3,
  input  logic       q4,
  input  logic       q5,
  output logic [2:0] pos,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pass_count
);

  localparam logic [3:0] PASS_TARGET = 4'(NUM_PASSES);
  localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT - 1);

  logic [4:0] v;
  logic [2:0] enc_pos;

  logic [2:0] state_q, state_d;
  logic [2:0] exp_q,   exp_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] pc_q,    pc_d;
  logic [2:0] pos_q;
  logic       busy_q, done_q, err_q;
  logic [3:0] pc_inc;

  assign v = {q5, q4, q3, q2, q1};

  // The same encoder drives pos and the one-hot check: v equals one-hot(exp)
  // exactly when its encoded position equals exp, since exp is never 0 or 7.
  d_array_onehot_enc u_enc (
    .vec_i (v),
    .pos_o (enc_pos)
  );

  assign pc_inc = pc_q + 4'd1;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    timer_d = timer_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_pos == POS_FIRST) begin
          state_d = ST_TRACK;
          exp_d   = 3'd2;
          pc_d    = 4'd0;
        end
      end
      ST_TRACK: begin
        if (enc_pos != exp_q) begin
          state_d = ST_ERR;
        end else if (exp_q != POS_LAST) begin
          exp_d = exp_q + 3'd1;
        end else begin
          pc_d = pc_inc;
          if (pc_inc == PASS_TARGET) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ARM;
            timer_d = 8'd0;
          end
        end
      end
      ST_ARM: begin
        // A launch wins over a timer expiring on the same edge.
        if (enc_pos == POS_FIRST) begin
          state_d = ST_TRACK;
          exp_d   = 3'd2;
        end else if (enc_pos == POS_NONE) begin
          timer_d = timer_q + 8'd1;
          if (timer_q == TIMER_LAST) begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      exp_q   <= 3'd0;
      timer_q <= 8'd0;
      pc_q    <= 4'd0;
      pos_q   <= POS_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      timer_q <= timer_d;
      pc_q    <= pc_d;
      pos_q   <= enc_pos;
      busy_q  <= state_is_busy(state_d);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign pos        = pos_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pass_count = pc_q;

endmodule

// File: tb/tb_d_array_tracker.sv
// tb_d_array_tracker
// Three tracker instances share clock, reset and taps:
//   dut 0: NUM_PASSES=1, TIMEOUT=15
//   dut 1: NUM_PASSES=3, TIMEOUT=15
//   dut 2: NUM_PASSES=2, TIMEOUT=4
// Each scenario plans per-cycle stimulus with hand-derived expected outputs,
// pushes the expectation to the scoreboard when the stimulus is driven and
// pops it once the sampling edge has produced the registered response.
module tb_d_array_tracker;

  logic clk = 1'b0;
  logic reset;
  logic q1, q2, q3, q4, q5;

  logic [2:0] pos_w  [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       err_w  [3];
  logic [3:0] pc_w   [3];

  always #5 clk = ~clk;

  d_array_tracker #(.NUM_PASSES(1), .TIMEOUT(15)) u_np1 (
    .clk(clk), .reset(reset), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
    .pos(pos_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .pass_count(pc_w[0])
  );

  d_array_tracker #(.NUM_PASSES(3), .TIMEOUT(15)) u_np3 (
    .clk(clk), .reset(reset), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
    .pos(pos_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .pass_count(pc_w[1])
  );

  d_array_tracker #(.NUM_PASSES(2), .TIMEOUT(4)) u_np2_to4 (
    .clk(clk), .reset(reset), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
    .pos(pos_w[2]), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]),
    .pass_count(pc_w[2])
  );

  typedef struct packed {
    logic       r;
    logic [4:0] v;
    logic [9:0] e;
  } step_t;

  step_t      plan [$];
  logic [9:0] sb_q [$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  // Expected output word: {pos, busy, done, err, pass_count}
  function automatic logic [9:0] E(input logic [2:0] p, input logic b,
                                   input logic dn, input logic er,
                                   input logic [3:0] c);
    return {p, b, dn, er, c};
  endfunction

  function automatic logic [9:0] obs(input int d);
    return {pos_w[d], busy_w[d], done_w[d], err_w[d], pc_w[d]};
  endfunction

  function automatic string fmt(input logic [9:0] w);
    return $sformatf("pos=%0d busy=%b done=%b err=%b pass_count=%0d",
                     w[9:7], w[6], w[5], w[4], w[3:0]);
  endfunction

  task automatic add(input logic r, input logic [4:0] v, input logic [9:0] e);
    step_t s;
    s.r = r; s.v = v; s.e = e;
    plan.push_back(s);
  endtask

  task automatic drive(input logic r, input logic [4:0] v);
    @(negedge clk);
    reset = r;
    {q5, q4, q3, q2, q1} = v;
  endtask

  // One clean walk q1..q4 (pos 1..4) with busy high and a given pass count.
  task automatic add_walk14(input logic [3:0] c);
    add(0, 5'b00001, E(3'd1, 1, 0, 0, c));
    add(0, 5'b00010, E(3'd2, 1, 0, 0, c));
    add(0, 5'b00100, E(3'd3, 1, 0, 0, c));
    add(0, 5'b01000, E(3'd4, 1, 0, 0, c));
  endtask

  task automatic test_reset;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add(1, 5'b00001, E(3'd0, 0, 0, 0, 4'd0));
    add(1, 5'b10101, E(3'd0, 0, 0, 0, 4'd0));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(0); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_single_pass;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add_walk14(4'd0);
    add(0, 5'b10000, E(3'd5, 0, 1, 0, 4'd1));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd1));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd1));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(0); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL single_pass step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_multi_pass;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    for (int p = 1; p <= 3; p++) begin
      add_walk14(4'(p - 1));
      if (p < 3) begin
        add(0, 5'b10000, E(3'd5, 1, 0, 0, 4'(p)));
        for (int g = 0; g < 3; g++) add(0, 5'b00000, E(3'd0, 1, 0, 0, 4'(p)));
      end else begin
        add(0, 5'b10000, E(3'd5, 0, 1, 0, 4'd3));
      end
    end
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd3));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd3));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(1); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL multi_pass step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_long_start;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add(0, 5'b00001, E(3'd1, 1, 0, 0, 4'd0));
    add(0, 5'b00011, E(3'd7, 0, 0, 1, 4'd0));
    add(0, 5'b00110, E(3'd7, 0, 0, 1, 4'd0));
    add(0, 5'b01100, E(3'd7, 0, 0, 1, 4'd0));
    add(0, 5'b11000, E(3'd7, 0, 0, 1, 4'd0));
    add(0, 5'b10000, E(3'd5, 0, 0, 1, 4'd0));
    for (int g = 0; g < 20; g++) add(0, 5'b00000, E(3'd0, 0, 0, 1, 4'd0));
    add(0, 5'b00001, E(3'd1, 0, 0, 1, 4'd0));
    add(0, 5'b00100, E(3'd3, 0, 0, 1, 4'd0));
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(0); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL long_start step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_arm_timeout;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add_walk14(4'd0);
    add(0, 5'b10000, E(3'd5, 1, 0, 0, 4'd1));
    for (int g = 0; g < 3; g++) add(0, 5'b00000, E(3'd0, 1, 0, 0, 4'd1));
    add(0, 5'b00000, E(3'd0, 0, 0, 1, 4'd1));
    for (int g = 0; g < 3; g++) add(0, 5'b00000, E(3'd0, 0, 0, 1, 4'd1));
    add(0, 5'b00001, E(3'd1, 0, 0, 1, 4'd1));
    add(0, 5'b00010, E(3'd2, 0, 0, 1, 4'd1));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(2); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL arm_timeout step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_launch_at_expiry;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add_walk14(4'd0);
    add(0, 5'b10000, E(3'd5, 1, 0, 0, 4'd1));
    for (int g = 0; g < 3; g++) add(0, 5'b00000, E(3'd0, 1, 0, 0, 4'd1));
    add_walk14(4'd1);
    add(0, 5'b10000, E(3'd5, 0, 1, 0, 4'd2));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd2));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(2); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL launch_at_expiry step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_pass;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add(0, 5'b00001, E(3'd1, 1, 0, 0, 4'd0));
    add(0, 5'b00010, E(3'd2, 1, 0, 0, 4'd0));
    add(0, 5'b00100, E(3'd3, 1, 0, 0, 4'd0));
    add(1, 5'b01000, E(3'd0, 0, 0, 0, 4'd0));
    add(0, 5'b10000, E(3'd5, 0, 0, 0, 4'd0));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add_walk14(4'd0);
    add(0, 5'b10000, E(3'd5, 0, 1, 0, 4'd1));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd1));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(0); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid_pass step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  task automatic test_stray_idle;
    step_t s; logic [9:0] got, want; int k = 0;
    add(1, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add(0, 5'b00100, E(3'd3, 0, 0, 0, 4'd0));
    add(0, 5'b10101, E(3'd7, 0, 0, 0, 4'd0));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    add(0, 5'b10000, E(3'd5, 0, 0, 0, 4'd0));
    add(0, 5'b00011, E(3'd7, 0, 0, 0, 4'd0));
    add(0, 5'b00000, E(3'd0, 0, 0, 0, 4'd0));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      drive(s.r, s.v); sb_q.push_back(s.e);
      @(posedge clk); #1;
      got = obs(0); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL stray_idle step %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {q5, q4, q3, q2, q1} = 5'b00000;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_long_start();
    test_arm_timeout();
    test_launch_at_expiry();
    test_reset_mid_pass();
    test_stray_idle();
    if (sb_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
